// File: rtl/rtype_program_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rtype_pkg
// Description : Shared R-type constants and the loader state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package rtype_pkg;

    localparam logic [5:0] c_OP_RTYPE  = 6'b000000;

    localparam logic [5:0] c_FUNCT_SLL = 6'h00;
    localparam logic [5:0] c_FUNCT_SRL = 6'h02;
    localparam logic [5:0] c_FUNCT_ADD = 6'h20;
    localparam logic [5:0] c_FUNCT_SUB = 6'h22;
    localparam logic [5:0] c_FUNCT_AND = 6'h24;
    localparam logic [5:0] c_FUNCT_OR  = 6'h25;
    localparam logic [5:0] c_FUNCT_NOR = 6'h27;
    localparam logic [5:0] c_FUNCT_SLT = 6'h2A;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/rtype_program_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : rtype_program_loader_if
// Description : Field-bundle handshake plus instruction-memory write bus.
// Revision    : 1.0 - initial release
// ============================================================================
interface rtype_program_loader_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [5:0]        funct;
    logic              last;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    // master: bundle producer / memory side; slave: the loader
    modport master (
        output in_valid, rs, rt, rd, shamt, funct, last,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, rs, rt, rd, shamt, funct, last,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/rtype_program_loader_encoder.sv
`default_nettype none
// ============================================================================
// Module      : rtype_encoder
// Description : Combinational R-type field encoder with funct legality check.
// Revision    : 1.0 - initial release
// ============================================================================
module rtype_encoder
    import rtype_pkg::*;
(
    input  wire logic [4:0]  rs,
    input  wire logic [4:0]  rt,
    input  wire logic [4:0]  rd,
    input  wire logic [4:0]  shamt,
    input  wire logic [5:0]  funct,
    output logic      [31:0] word,
    output logic             legal
);

    logic       w_is_shift;
    logic [4:0] w_shamt_eff;

    always_comb begin
        legal = 1'b0;
        case (funct)
            c_FUNCT_SLL, c_FUNCT_SRL, c_FUNCT_ADD, c_FUNCT_SUB,
            c_FUNCT_AND, c_FUNCT_OR,  c_FUNCT_NOR, c_FUNCT_SLT: legal = 1'b1;
            default:                                            legal = 1'b0;
        endcase
    end

    // Only the shift instructions carry a shift amount; others encode zero.
    assign w_is_shift  = (funct == c_FUNCT_SLL) || (funct == c_FUNCT_SRL);
    assign w_shamt_eff = w_is_shift ? shamt : 5'd0;
    assign word        = {c_OP_RTYPE, rs, rt, rd, w_shamt_eff, funct};

endmodule
`default_nettype wire

// File: rtl/rtype_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : rtype_program_loader
// Description : Encodes R-type bundles into imem words and releases the core.
// Revision    : 1.0 - initial release
// ============================================================================
module rtype_program_loader
    import rtype_pkg::*;
#(
    parameter int                ADDR_W    = 8,
    parameter int                DEPTH     = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic               start,
    rtype_program_loader_if.slave   bus,
    output logic                    core_run,
    output logic [6:0]              count,
    output logic                    err,
    output logic                    full,
    output logic                    busy
);

    localparam logic [1:0] c_IDLE  = 2'(IDLE);
    localparam logic [1:0] c_LOAD  = 2'(LOAD);
    localparam logic [1:0] c_WRITE = 2'(WRITE);
    localparam logic [1:0] c_DONE  = 2'(DONE);

    localparam logic [6:0]        c_DEPTH    = 7'(DEPTH);
    localparam logic [ADDR_W-1:0] c_ADDR_INC = ADDR_W'(4);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [6:0]        r_count;
    logic              r_err;
    logic              r_full;
    logic              r_last;

    logic [31:0] w_word;
    logic        w_legal;
    logic [6:0]  w_count_inc;
    logic        w_depth_hit;

    rtype_encoder u_encoder (
        .rs    (bus.rs),
        .rt    (bus.rt),
        .rd    (bus.rd),
        .shamt (bus.shamt),
        .funct (bus.funct),
        .word  (w_word),
        .legal (w_legal)
    );

    assign w_count_inc = r_count + 7'd1;
    assign w_depth_hit = (w_count_inc == c_DEPTH);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_IDLE;
            r_addr  <= BASE_ADDR;
            r_wdata <= 32'd0;
            r_count <= 7'd0;
            r_err   <= 1'b0;
            r_full  <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (start) begin
                        r_state <= c_LOAD;
                        r_addr  <= BASE_ADDR;
                        r_count <= 7'd0;
                        r_err   <= 1'b0;
                        r_full  <= 1'b0;
                    end
                end
                c_LOAD: begin
                    if (bus.in_valid) begin
                        if (w_legal) begin
                            r_wdata <= w_word;
                            r_last  <= bus.last;
                            r_state <= c_WRITE;
                        end else begin
                            // Illegal bundle is swallowed; only the sticky flag records it.
                            r_err <= 1'b1;
                            if (bus.last) begin
                                r_state <= c_DONE;
                            end
                        end
                    end
                end
                c_WRITE: begin
                    r_addr  <= r_addr + c_ADDR_INC;
                    r_count <= w_count_inc;
                    if (r_last || w_depth_hit) begin
                        r_state <= c_DONE;
                    end else begin
                        r_state <= c_LOAD;
                    end
                    if (!r_last && w_depth_hit) begin
                        r_full <= 1'b1;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Strobes decode straight from state so reset drops them without a clock.
    assign bus.in_ready   = (r_state == c_LOAD);
    assign bus.imem_we    = (r_state == c_WRITE);
    assign bus.imem_addr  = r_addr;
    assign bus.imem_wdata = r_wdata;

    assign core_run = (r_state == c_DONE);
    assign busy     = (r_state == c_LOAD) || (r_state == c_WRITE);
    assign count    = r_count;
    assign err      = r_err;
    assign full     = r_full;

endmodule
`default_nettype wire

// File: tb/tb_rtype_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_rtype_program_loader
// Description : Directed self-checking bench for the R-type program loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rtype_program_loader;

    localparam int         ADDR_W = 8;
    localparam int         DEPTH  = 4;
    localparam logic [7:0] BASE   = 8'h40;

    logic       clk = 1'b0;
    logic       reset;
    logic       start = 1'b0;
    logic       core_run;
    logic [6:0] count;
    logic       err;
    logic       full;
    logic       busy;

    rtype_program_loader_if #(.ADDR_W(ADDR_W)) bus ();

    rtype_program_loader #(
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bus      (bus),
        .core_run (core_run),
        .count    (count),
        .err      (err),
        .full     (full),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  wr_addr [16];
    logic [31:0] wr_data [16];
    int          n_wr = 0;

    // Write log, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            if (n_wr < 16) begin
                wr_addr[n_wr] = bus.imem_addr;
                wr_data[n_wr] = bus.imem_wdata;
            end
            n_wr = n_wr + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic pulse_start;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the transfer edge.
    task automatic send(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [4:0] sh, input logic [5:0] f, input logic l,
                        input logic exp_rdy_after, input string tag);
        int n = 0;
        bus.rs = rs; bus.rt = rt; bus.rd = rd; bus.shamt = sh;
        bus.funct = f; bus.last = l; bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            check({tag, "_accept_timeout"}, 32'(bus.in_ready), 32'd1);
        end else begin
            @(negedge clk);
            check({tag, "_rdy_after"}, 32'(bus.in_ready), 32'(exp_rdy_after));
        end
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (core_run !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_core_run"}, 32'(core_run), 32'd1);
    endtask

    initial begin
        int rdy_seen;
        bus.in_valid = 1'b0; bus.rs = '0; bus.rt = '0; bus.rd = '0;
        bus.shamt = '0; bus.funct = '0; bus.last = 1'b0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        check("rst_in_ready", 32'(bus.in_ready),   32'd0);
        check("rst_we",       32'(bus.imem_we),    32'd0);
        check("rst_addr",     32'(bus.imem_addr),  32'(BASE));
        check("rst_wdata",    bus.imem_wdata,      32'd0);
        check("rst_core_run", 32'(core_run),       32'd0);
        check("rst_flags",    {count, err, full, busy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Single add, last
        n_wr = 0;
        pulse_start();
        send(5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 1'b1, 1'b0, "t1");
        bus.in_valid = 1'b0;
        wait_done("t1");
        check("t1_nwr",   32'(n_wr),          32'd1);
        check("t1_addr0", 32'(wr_addr[0]),    32'h40);
        check("t1_data0", wr_data[0],         32'h00221820);
        check("t1_count", 32'(count),         32'd1);
        check("t1_err",   32'(err),           32'd0);
        check("t1_full",  32'(full),          32'd0);
        check("t1_busy",  32'(busy),          32'd0);
        check("t1_addr",  32'(bus.imem_addr), 32'h44);

        // Back-to-back add/sub/sll with in_valid held
        n_wr = 0;
        pulse_start();
        check("t2_run_drop", 32'(core_run), 32'd0);
        check("t2_count0",   32'(count),    32'd0);
        send(5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 1'b0, 1'b0, "t2a");
        send(5'd3, 5'd1, 5'd4, 5'd0, 6'h22, 1'b0, 1'b0, "t2b");
        send(5'd0, 5'd2, 5'd5, 5'd4, 6'h00, 1'b1, 1'b0, "t2c");
        bus.in_valid = 1'b0;
        wait_done("t2");
        check("t2_nwr",   32'(n_wr),       32'd3);
        check("t2_addr0", 32'(wr_addr[0]), 32'h40);
        check("t2_data0", wr_data[0],      32'h00221820);
        check("t2_addr1", 32'(wr_addr[1]), 32'h44);
        check("t2_data1", wr_data[1],      32'h00612022);
        check("t2_addr2", 32'(wr_addr[2]), 32'h48);
        check("t2_data2", wr_data[2],      32'h00022900);
        check("t2_count", 32'(count),      32'd3);

        // shamt masking and illegal funct mid-program
        n_wr = 0;
        pulse_start();
        send(5'd1, 5'd2, 5'd3, 5'd7, 6'h20, 1'b0, 1'b0, "t3a");
        send(5'd1, 5'd2, 5'd3, 5'd0, 6'h08, 1'b0, 1'b1, "t3ill");
        check("t3_ill_addr",  32'(bus.imem_addr), 32'h44);
        check("t3_ill_err",   32'(err),           32'd1);
        check("t3_ill_count", 32'(count),         32'd1);
        send(5'd5, 5'd6, 5'd7, 5'd0, 6'h20, 1'b1, 1'b0, "t3c");
        bus.in_valid = 1'b0;
        wait_done("t3");
        check("t3_nwr",   32'(n_wr),       32'd2);
        check("t3_data0", wr_data[0],      32'h00221820);
        check("t3_addr1", 32'(wr_addr[1]), 32'h44);
        check("t3_data1", wr_data[1],      32'h00A63820);
        check("t3_err",   32'(err),        32'd1);
        check("t3_count", 32'(count),      32'd2);

        // DEPTH overflow: no last ever given
        n_wr = 0;
        pulse_start();
        check("t4_err_clr", 32'(err), 32'd0);
        send(5'd1, 5'd2, 5'd3, 5'd0,  6'h20, 1'b0, 1'b0, "t4a");
        send(5'd0, 5'd3, 5'd1, 5'd31, 6'h02, 1'b0, 1'b0, "t4b");
        send(5'd1, 5'd2, 5'd3, 5'd0,  6'h24, 1'b0, 1'b0, "t4c");
        send(5'd1, 5'd2, 5'd3, 5'd0,  6'h2A, 1'b0, 1'b0, "t4d");
        bus.funct = 6'h25;
        rdy_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) rdy_seen++;
        end
        bus.in_valid = 1'b0;
        check("t4_rdy_seen", 32'(rdy_seen),       32'd0);
        check("t4_core_run", 32'(core_run),       32'd1);
        check("t4_full",     32'(full),           32'd1);
        check("t4_count",    32'(count),          32'd4);
        check("t4_nwr",      32'(n_wr),           32'd4);
        check("t4_data1",    wr_data[1],          32'h00030FC2);
        check("t4_data2",    wr_data[2],          32'h00221824);
        check("t4_data3",    wr_data[3],          32'h0022182A);
        check("t4_addr3",    32'(wr_addr[3]),     32'h4C);
        check("t4_addr",     32'(bus.imem_addr),  32'h50);

        // Restart from DONE, then zero-length program
        n_wr = 0;
        pulse_start();
        check("t5_core_run", 32'(core_run),      32'd0);
        check("t5_flags",    {count, err, full}, 32'd0);
        check("t5_addr",     32'(bus.imem_addr), 32'(BASE));
        check("t5_busy",     32'(busy),          32'd1);
        send(5'd1, 5'd2, 5'd3, 5'd0, 6'h3F, 1'b1, 1'b0, "t5z");
        bus.in_valid = 1'b0;
        wait_done("t5");
        check("t5_count", 32'(count), 32'd0);
        check("t5_err",   32'(err),   32'd1);
        check("t5_nwr",   32'(n_wr),  32'd0);

        // Reset asserted during WRITE
        pulse_start();
        send(5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 1'b0, 1'b0, "t6");
        bus.in_valid = 1'b0;
        check("t6_we_pre",    32'(bus.imem_we), 32'd1);
        check("t6_wdata_pre", bus.imem_wdata,   32'h00221820);
        #1 reset = 1'b0;
        #1;
        check("t6_we",       32'(bus.imem_we),    32'd0);
        check("t6_in_ready", 32'(bus.in_ready),   32'd0);
        check("t6_addr",     32'(bus.imem_addr),  32'(BASE));
        check("t6_wdata",    bus.imem_wdata,      32'd0);
        check("t6_flags",    {count, err, full, busy, core_run}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        n_wr = 0;
        repeat (3) @(negedge clk);
        check("t6_nwr",      32'(n_wr),     32'd0);
        check("t6_busy",     32'(busy),     32'd0);
        check("t6_core_run", 32'(core_run), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rtype_program_loader.md
Name: rtype_program_loader

Overview:
Loads R-type programs into instruction memory ahead of execution by the R-type datapath. It accepts decoded R-type fields (rs, rt, rd, shamt, funct) over a valid/ready handshake and encodes each into a 32-bit MIPS R-type word (opcode 0). Each word is written to consecutive instruction-memory addresses. The datapath is held stopped until loading completes, then released via core_run.

Parameters:
ADDR_W, 8, width of byte address to instruction memory
DEPTH, 64, maximum words loadable per program
BASE_ADDR, 0, byte address of first instruction (word aligned)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begins a new load
in_valid  in  1  field bundle valid
in_ready  out  1  loader accepts bundle this cycle
rs  in  5  source register 1
rt  in  5  source register 2
rd  in  5  destination register
shamt  in  5  shift amount
funct  in  6  function code
last  in  1  bundle is final instruction of program
imem_we  out  1  instruction-memory write strobe
imem_addr  out  ADDR_W  byte write address
imem_wdata  out  32  encoded instruction
core_run  out  1  high = datapath may execute
count  out  7  words written in current load (0..DEPTH)
err  out  1  sticky: illegal funct seen in current load
full  out  1  sticky: DEPTH reached before last
busy  out  1  high in LOAD/WRITE

Behaviour:
- Reset (reset low, asynchronous): state IDLE; in_ready 0, imem_we 0, imem_addr BASE_ADDR, imem_wdata 0, core_run 0, count 0, err 0, full 0, busy 0. Reset mid-load abandons the load; imem_we falls immediately; no partial word is written after reset deasserts.
- Encoding: word = {6'b000000, rs, rt, rd, shamt_eff, funct}. Legal funct: sll 0x00, srl 0x02, add 0x20, sub 0x22, and 0x24, or 0x25, nor 0x27, slt 0x2A. shamt_eff = shamt for sll/srl, else 0.
- States: IDLE, LOAD, WRITE, DONE.
- IDLE: in_ready 0. start -> LOAD; addr = BASE_ADDR, count 0, err 0, full 0, core_run 0.
- LOAD: in_ready 1, busy 1. A transfer occurs when in_valid && in_ready. Legal funct: register encoded word into imem_wdata, latch last, -> WRITE. Illegal funct: bundle consumed, nothing written, err set; -> DONE if last, else stay LOAD.
- WRITE: in_ready 0, imem_we 1 for exactly one cycle with current imem_addr and imem_wdata. Next edge: imem_addr += 4, count += 1. -> DONE if latched last, or if count+1 == DEPTH (also set full if last not latched). Else -> LOAD.
- Throughput: at most one word per 2 cycles. Latency: in_valid accepted at edge N gives the write strobe in cycle N+1.
- DONE: core_run 1, busy 0, in_ready 0; imem_addr/count hold final values. start -> LOAD; core_run falls at that same edge, and addr/count/err/full reinitialise.
- start is ignored in LOAD and WRITE. in_valid is ignored outside LOAD.
- Address wraps modulo 2^ADDR_W. DEPTH*4 + BASE_ADDR must not exceed 2^ADDR_W; this is the integrator's responsibility.
- Zero-length program: start, then an illegal funct with last -> DONE, count 0, err 1, core_run 1.

Decomposition:
- Shared package rtype_pkg holds: the R-type opcode constant 6'b000000, the funct constants listed above, and the state enum {IDLE, LOAD, WRITE, DONE}.
- One combinational sub-module, rtype_encoder: inputs rs, rt, rd, shamt, funct; outputs word[31:0] and legal. It is reused by the datapath bench for golden checks.

Test Plan:
- Reset low mid-WRITE -> imem_we 0 at once; all outputs at reset values; after release, state IDLE and no write issued.
- start; single bundle rs=1 rt=2 rd=3 shamt=0 funct=0x20 last=1 -> one write, addr 0x00, data 0x00221820; count 1, core_run 1, err 0.
- Three bundles with in_valid held high: add above; sub rs=3 rt=1 rd=4 funct=0x22; sll rt=2 rd=5 shamt=4 funct=0x00 last -> writes at 0x00, 0x04, 0x08 with data 0x00221820, 0x00612022, 0x00022900; in_ready low every other cycle.
- add with shamt=7 -> data 0x00221820 (shamt forced to 0); funct=0x08 mid-program -> no write, err 1, addr not advanced, next legal word written at next address.
- DEPTH=4, six bundles without last -> four writes, full 1, DONE after the 4th write; remaining bundles see in_ready 0.
- In DONE, pulse start -> core_run drops the next cycle; count 0, err 0; a new load begins at BASE_ADDR.
